alu_sequencer: RTL and testbench

Sequential front end for the combinational ALU: accepts 16-bit register-register instructions over a valid/ready handshake, reads operands from an internal 16x16 register file, drives the ALU operand/opcode inputs, captures the result and the four flags, and writes back. It is the driving end of the ALU interface, sitting between instruction fetch and the ALU in the datapath.

---
 rtl/alu_sequencer.sv | 154 +++++++++++++++
 tb/tb_alu_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: IDLE/READ/EXEC/WB front end that feeds an external combinational ALU from a 16-entry register file.
// Define ALU_SEQ_DEBUG_EN to add a combinational register-file read port (Dbg_Addr/Dbg_Data).
module alu_sequencer #(
  parameter int REGS  = 16,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [15:0]      Instr,
  input  logic             Instr_Valid,
  output logic             Instr_Ready,
  input  logic             Ld_En,
  input  logic [3:0]       Ld_Addr,
  input  logic [WIDTH-1:0] Ld_Data,
  output logic [WIDTH-1:0] Alu_A,
  output logic [WIDTH-1:0] Alu_B,
  output logic [3:0]       Alu_Opcode,
  input  logic [WIDTH-1:0] Alu_C,
  input  logic             Alu_Flag,
  input  logic             Alu_Low,
  input  logic             Alu_Negative,
  input  logic             Alu_Zero,
`ifdef ALU_SEQ_DEBUG_EN
  input  logic [3:0]       Dbg_Addr,
  output logic [WIDTH-1:0] Dbg_Data,
`endif
  output logic [3:0]       Psr,
  output logic             Done,
  output logic             Bad_Op
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_CMP  = 4'h2;
  localparam logic [3:0] OP_CMPR = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_LSH  = 4'h8;
  localparam logic [3:0] OP_RSH  = 4'h9;
  localparam logic [3:0] OP_ARSH = 4'hA;

  state_t           r_state;
  state_t           w_nextState;
  logic             w_ready;
  logic             w_accept;
  logic             w_load;
  logic             w_opDefined;
  logic             w_wrEn;
  logic [15:0]      r_instr;
  logic [WIDTH-1:0] r_rf [REGS];
  logic [WIDTH-1:0] r_aluA;
  logic [WIDTH-1:0] r_aluB;
  logic [3:0]       r_aluOp;
  logic [WIDTH-1:0] r_capC;
  logic [3:0]       r_capFlags;
  logic [3:0]       r_psr;
  logic             r_done;
  logic             r_badOp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        w_load  = Ld_En;
        if (Instr_Valid) begin
          w_accept    = 1'b1;
          w_nextState = READ;
        end
      end
      READ:    w_nextState = EXEC;
      EXEC:    w_nextState = WB;
      WB:      w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_opDefined = 1'b0;
    case (r_instr[15:12])
      OP_ADD, OP_SUB, OP_CMP, OP_CMPR, OP_AND, OP_OR,
      OP_XOR, OP_NOT, OP_LSH, OP_RSH, OP_ARSH: w_opDefined = 1'b1;
      default:                                 w_opDefined = 1'b0;
    endcase
    w_wrEn = w_opDefined && (r_instr[15:12] != OP_CMP) && (r_instr[15:12] != OP_CMPR);
  end

  // Done is registered so it pulses in the IDLE cycle right after writeback,
  // which is also the first cycle a dependent instruction can be accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instr    <= '0;
      r_aluA     <= '0;
      r_aluB     <= '0;
      r_aluOp    <= '0;
      r_capC     <= '0;
      r_capFlags <= '0;
      r_psr      <= '0;
      r_done     <= 1'b0;
      r_badOp    <= 1'b0;
      for (int i = 0; i < REGS; i++) r_rf[i] <= '0;
    end else begin
      r_done  <= 1'b0;
      r_badOp <= 1'b0;
      if (w_load)   r_rf[Ld_Addr] <= Ld_Data;
      if (w_accept) r_instr <= Instr;
      case (r_state)
        READ: begin
          r_aluA  <= r_rf[r_instr[7:4]];
          r_aluB  <= r_rf[r_instr[3:0]];
          r_aluOp <= r_instr[15:12];
        end
        EXEC: begin
          r_capC     <= Alu_C;
          r_capFlags <= {Alu_Flag, Alu_Low, Alu_Negative, Alu_Zero};
        end
        WB: begin
          if (w_wrEn) r_rf[r_instr[11:8]] <= r_capC;
          r_psr   <= r_capFlags;
          r_done  <= 1'b1;
          r_badOp <= !w_opDefined;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_DEBUG_EN
  assign Dbg_Data = r_rf[Dbg_Addr];
`else
  // Without the debug port the register file is observable only through execution.
`endif

  assign Instr_Ready = w_ready;
  assign Alu_A       = r_aluA;
  assign Alu_B       = r_aluB;
  assign Alu_Opcode  = r_aluOp;
  assign Psr         = r_psr;
  assign Done        = r_done;
  assign Bad_Op      = r_badOp;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed test of alu_sequencer with a bench-side ALU, a transaction-level
// reference model checked every cycle, and hand-computed literal expectations.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] Instr;
  logic        Instr_Valid;
  logic        Instr_Ready;
  logic        Ld_En;
  logic [3:0]  Ld_Addr;
  logic [15:0] Ld_Data;
  logic [15:0] Alu_A;
  logic [15:0] Alu_B;
  logic [3:0]  Alu_Opcode;
  logic [15:0] Alu_C;
  logic [19:0] aluOut;
  logic [3:0]  Psr;
  logic        Done;
  logic        Bad_Op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Reference ALU: returns {Flag, Low, Negative, Zero, Result}; undefined opcodes yield all zeros.
  function automatic logic [19:0] aluFn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] w;
    logic [15:0] r;
    logic        f;
    logic        l;
    r = '0; f = 1'b0; l = 1'b0; w = '0;
    case (op)
      4'h0: begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; l = w[16]; f = (a[15] == b[15]) && (r[15] != a[15]); end
      4'h1, 4'h2: begin r = a - b; l = (a < b); f = (a[15] != b[15]) && (r[15] != a[15]); end
      4'h3: begin r = b - a; l = (b < a); f = (a[15] != b[15]) && (r[15] != b[15]); end
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h7: r = ~a;
      4'h8: r = a << b[3:0];
      4'h9: r = a >> b[3:0];
      4'hA: r = $signed(a) >>> b[3:0];
      default: return 20'h0;
    endcase
    return {f, l, r[15], (r == 16'h0), r};
  endfunction

  function automatic bit opDefined(input logic [3:0] op);
    return op <= 4'hA;
  endfunction

  assign aluOut = aluFn(Alu_Opcode, Alu_A, Alu_B);
  assign Alu_C  = aluOut[15:0];

  alu_sequencer #(.REGS(16), .WIDTH(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .Instr       (Instr),
    .Instr_Valid (Instr_Valid),
    .Instr_Ready (Instr_Ready),
    .Ld_En       (Ld_En),
    .Ld_Addr     (Ld_Addr),
    .Ld_Data     (Ld_Data),
    .Alu_A       (Alu_A),
    .Alu_B       (Alu_B),
    .Alu_Opcode  (Alu_Opcode),
    .Alu_C       (Alu_C),
    .Alu_Flag    (aluOut[19]),
    .Alu_Low     (aluOut[18]),
    .Alu_Negative(aluOut[17]),
    .Alu_Zero    (aluOut[16]),
    .Psr         (Psr),
    .Done        (Done),
    .Bad_Op      (Bad_Op)
  );

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted instruction reads operands one edge later and
  // commits its result, flags and Done pulse three edges after acceptance.
  logic [15:0] mRegs [16];
  bit          pend = 0;
  logic [3:0]  pOp, pDest, pSrcA, pSrcB;
  int          cyc = 0, rdCyc = 0, wbCyc = 0;
  logic [15:0] expA = '0, expB = '0;
  logic [3:0]  expOp = '0, mPsr = '0;
  bit          mDone = 0, mBad = 0, idleBefore;
  logic [19:0] mRes;

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) mRegs[i] = '0;
      pend = 0; cyc = 0; expA = '0; expB = '0; expOp = '0;
      mPsr = '0; mDone = 0; mBad = 0;
    end else begin
      cyc++;
      mDone = 0;
      mBad = 0;
      idleBefore = !pend;
      if (pend && cyc == wbCyc) begin
        mRes = aluFn(expOp, expA, expB);
        if (opDefined(expOp) && expOp != 4'h2 && expOp != 4'h3) mRegs[pDest] = mRes[15:0];
        mPsr = mRes[19:16];
        mDone = 1;
        mBad = !opDefined(expOp);
        pend = 0;
      end
      if (pend && cyc == rdCyc) begin
        expA = mRegs[pSrcA];
        expB = mRegs[pSrcB];
        expOp = pOp;
      end
      if (idleBefore) begin
        if (Ld_En) mRegs[Ld_Addr] = Ld_Data;
        if (Instr_Valid) begin
          pend = 1;
          {pOp, pDest, pSrcA, pSrcB} = Instr;
          rdCyc = cyc + 1;
          wbCyc = cyc + 3;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    checkOutput("Instr_Ready", {15'h0, Instr_Ready}, {15'h0, !pend});
    checkOutput("Done", {15'h0, Done}, {15'h0, mDone});
    checkOutput("Bad_Op", {15'h0, Bad_Op}, {15'h0, mBad});
    checkOutput("Psr", {12'h0, Psr}, {12'h0, mPsr});
    checkOutput("Alu_A", Alu_A, expA);
    checkOutput("Alu_B", Alu_B, expB);
    checkOutput("Alu_Opcode", {12'h0, Alu_Opcode}, {12'h0, expOp});
  end

  // Issues one instruction, optionally holding Instr_Valid and/or pulsing a load at a given
  // cycle (0 = same cycle as accept), and returns Done latency in edges plus Bad_Op at Done.
  task automatic applyStimulus(input logic [3:0] op, input logic [3:0] d, input logic [3:0] a,
                               input logic [3:0] b, input int holdCycles, input int ldCycle,
                               input logic [3:0] ldA, input logic [15:0] ldD,
                               output int lat, output logic bad);
    int waits;
    lat = 0; bad = 1'b0; waits = 0;
    @(negedge clk);
    while (!Instr_Ready && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    if (!Instr_Ready) checkOutput("readyWait", 16'h0, 16'h1);
    Instr = {op, d, a, b};
    Instr_Valid = 1'b1;
    Ld_Addr = ldA;
    Ld_Data = ldD;
    Ld_En = (ldCycle == 0);
    @(posedge clk);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      Ld_En = (n == ldCycle);
      if (n > holdCycles) Instr_Valid = 1'b0;
      @(posedge clk);
      #1;
      if (Done) begin
        lat = n;
        bad = Bad_Op;
        break;
      end
    end
    Ld_En = 1'b0;
    Instr_Valid = 1'b0;
    checkOutput("doneSeen", {15'h0, lat != 0}, 16'h1);
  endtask

  task automatic loadReg(input logic [3:0] addr, input logic [15:0] data);
    @(negedge clk);
    Ld_En = 1'b1;
    Ld_Addr = addr;
    Ld_Data = data;
    @(negedge clk);
    Ld_En = 1'b0;
  endtask

  // Reads a register by running CMP R0,Rr,Rr (no writeback) and sampling the held Alu_A.
  task automatic readReg(input logic [3:0] r, output logic [15:0] v);
    int   lat;
    logic bad;
    applyStimulus(4'h2, 4'h0, r, r, 0, -1, 4'h0, 16'h0, lat, bad);
    v = Alu_A;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int          lat;
    logic        bad;
    logic [15:0] v;
    reset_n = 1'b0; Instr = '0; Instr_Valid = 1'b0; Ld_En = 1'b0; Ld_Addr = '0; Ld_Data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("resetReady", {15'h0, Instr_Ready}, 16'h1);
    checkOutput("resetPsr", {12'h0, Psr}, 16'h0);
    checkOutput("resetDone", {15'h0, Done}, 16'h0);
    checkOutput("resetAluA", Alu_A, 16'h0);

    loadReg(4'd1, 16'h7FFF);
    loadReg(4'd2, 16'h0001);
    applyStimulus(4'h0, 4'd3, 4'd1, 4'd2, 0, -1, 4'h0, 16'h0, lat, bad);
    checkOutput("addLatency", 16'(lat), 16'd3);
    checkOutput("addPsr", {12'h0, Psr}, 16'b1010);
    checkOutput("addBadOp", {15'h0, bad}, 16'h0);
    readReg(4'd3, v);
    checkOutput("addR3", v, 16'h8000);

    loadReg(4'd4, 16'h1234);
    loadReg(4'd5, 16'h1234);
    loadReg(4'd7, 16'h5555);
    applyStimulus(4'h1, 4'd6, 4'd4, 4'd5, 0, -1, 4'h0, 16'h0, lat, bad);
    checkOutput("subPsr", {12'h0, Psr}, 16'b0001);
    applyStimulus(4'h2, 4'd7, 4'd4, 4'd5, 0, -1, 4'h0, 16'h0, lat, bad);
    checkOutput("cmpPsr", {12'h0, Psr}, 16'b0001);
    readReg(4'd6, v);
    checkOutput("subR6", v, 16'h0000);
    readReg(4'd7, v);
    checkOutput("cmpR7Kept", v, 16'h5555);

    loadReg(4'd1, 16'h8000);
    loadReg(4'd2, 16'h0004);
    applyStimulus(4'hA, 4'd8, 4'd1, 4'd2, 0, -1, 4'h0, 16'h0, lat, bad);
    applyStimulus(4'h5, 4'd10, 4'd8, 4'd0, 0, -1, 4'h0, 16'h0, lat, bad);
    applyStimulus(4'h6, 4'd9, 4'd8, 4'd8, 0, -1, 4'h0, 16'h0, lat, bad);
    checkOutput("xorPsr", {12'h0, Psr}, 16'b0001);
    readReg(4'd10, v);
    checkOutput("depR10", v, 16'hF800);
    readReg(4'd8, v);
    checkOutput("arshR8", v, 16'hF800);

    applyStimulus(4'hF, 4'd3, 4'd1, 4'd2, 0, -1, 4'h0, 16'h0, lat, bad);
    checkOutput("badOpPulse", {15'h0, bad}, 16'h1);
    checkOutput("badOpLatency", 16'(lat), 16'd3);
    checkOutput("badOpPsr", {12'h0, Psr}, 16'h0);
    readReg(4'd3, v);
    checkOutput("badOpR3Kept", v, 16'h8000);

    applyStimulus(4'h1, 4'd11, 4'd4, 4'd5, 2, 2, 4'd1, 16'hDEAD, lat, bad);
    readReg(4'd1, v);
    checkOutput("ldInExecIgnored", v, 16'h8000);

    applyStimulus(4'h5, 4'd13, 4'd12, 4'd0, 0, 0, 4'd12, 16'h00F0, lat, bad);
    readReg(4'd13, v);
    checkOutput("loadWithAccept", v, 16'h00F0);

    @(negedge clk);
    Instr = {4'h0, 4'd3, 4'd1, 4'd2};
    Instr_Valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Instr_Valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("midResetDone", {15'h0, Done}, 16'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("postResetReady", {15'h0, Instr_Ready}, 16'h1);
    checkOutput("postResetPsr", {12'h0, Psr}, 16'h0);
    repeat (4) @(posedge clk);
    readReg(4'd1, v);
    checkOutput("postResetR1", v, 16'h0);
    readReg(4'd8, v);
    checkOutput("postResetR8", v, 16'h0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
